// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// seg_scan_ctrl : four-digit multiplexed seven-segment scanner, 3 pages,
//                 debounced page-step button.            Revision: 1.0
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int SCAN_CYCLES     = 50000,
  parameter int BLANK_CYCLES    = 500,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        button_i,
  input  logic [15:0] page0_i,
  input  logic [15:0] page1_i,
  input  logic [15:0] page2_i,
  input  logic [3:0]  blank0_i,
  input  logic [3:0]  blank1_i,
  input  logic [3:0]  blank2_i,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_o,
  output logic [1:0]  page_o,
  output logic        page_strobe_o
);

  localparam int CNT_MAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic             btn_meta_q, btn_sync_q, btn_stable_q, btn_prev_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic [1:0]       page_q;
  logic             strobe_q;

  logic [15:0]      w_word;
  logic [3:0]       w_blank;

  always_comb begin
    case (page_q)
      2'd1:    begin w_word = page1_i; w_blank = blank1_i; end
      2'd2:    begin w_word = page2_i; w_blank = blank2_i; end
      default: begin w_word = page0_i; w_blank = blank0_i; end
    endcase
  end

  // Scan FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      scan_cnt_q <= '0;
      digit_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
    end
  end

  // Scan FSM: next state
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    case (state_q)
      ST_BLANK: begin
        if (scan_cnt_q == BLANK_LAST) begin
          state_d    = ST_DRIVE;
          scan_cnt_d = '0;
        end
      end
      default: begin
        if (scan_cnt_q == SCAN_LAST) begin
          state_d    = ST_BLANK;
          scan_cnt_d = '0;
          digit_d    = digit_q + 2'd1;
        end
      end
    endcase
  end

  // Scan FSM: outputs; the registered seg/an double as the per-visit snapshot
  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    if (state_d == ST_BLANK) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end else if (state_q == ST_BLANK) begin
      if (w_blank[digit_q]) begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end else begin
        seg_d = hex_decode(w_word[digit_q*4 +: 4]);
        an_d  = ~(4'b0001 << digit_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_stable_q <= 1'b0;
      btn_prev_q   <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      btn_meta_q <= button_i;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_stable_q;
      if (btn_sync_q == btn_stable_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        btn_stable_q <= btn_sync_q;
        db_cnt_q     <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // Page steps one cycle after the debounced level rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q   <= 2'd0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= btn_stable_q & ~btn_prev_q;
      if (btn_stable_q & ~btn_prev_q) begin
        page_q <= (page_q == 2'd2) ? 2'd0 : page_q + 2'd1;
      end
    end
  end

  assign seg_o         = seg_q;
  assign an_o          = an_q;
  assign page_o        = page_q;
  assign page_strobe_o = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// tb_seg_scan_ctrl : directed self-checking bench for seg_scan_ctrl.
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        button = 1'b0;
  logic [15:0] page0 = 16'h3A50;
  logic [15:0] page1 = 16'h0005;
  logic [15:0] page2 = 16'h4D6F;
  logic [3:0]  blank0 = 4'b0000;
  logic [3:0]  blank1 = 4'b1110;
  logic [3:0]  blank2 = 4'b0000;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  page;
  logic        page_strobe;

  int n_cmp = 0;
  int n_err = 0;
  int ncyc;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SF = 7'b0001110;

  seg_scan_ctrl #(
    .SCAN_CYCLES    (4),
    .BLANK_CYCLES   (2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_i     (button),
    .page0_i      (page0),
    .page1_i      (page1),
    .page2_i      (page2),
    .blank0_i     (blank0),
    .blank1_i     (blank1),
    .blank2_i     (blank2),
    .seg_o        (seg),
    .an_o         (an),
    .page_o       (page),
    .page_strobe_o(page_strobe)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; frame phase is derived from this alone
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  // Phase 0 = first DRIVE cycle of digit 0; each digit: 4 drive + 2 blank
  task automatic check_span(input int n, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] bm);
    logic [6:0] segs [4];
    logic [3:0] one;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int ph, d;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    one = 4'b0001;
    repeat (n) begin
      tick();
      ph = (ncyc + 22) % 24;
      d  = ph / 6;
      if ((ph % 6) < 4 && !bm[d]) begin
        e_an  = ~(one << d);
        e_seg = segs[d];
      end else begin
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
      end
      chk("an", {12'h0, an}, {12'h0, e_an});
      chk("seg", {9'h0, seg}, {9'h0, e_seg});
    end
  endtask

  task automatic press(input logic [1:0] old_pg, input logic [1:0] new_pg);
    button = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("press_page", {14'h0, page}, {14'h0, (i >= 11) ? new_pg : old_pg});
      chk("press_strobe", {15'h0, page_strobe}, {15'h0, (i == 11)});
    end
    button = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("release_page", {14'h0, page}, {14'h0, new_pg});
      chk("release_strobe", {15'h0, page_strobe}, 16'h0);
    end
  endtask

  task automatic sync_phase(input int target);
    for (int i = 0; i < 25; i++) begin
      if ((ncyc + 22) % 24 == target) break;
      tick();
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_page", {14'h0, page}, 16'h0);
    chk("rst_strobe", {15'h0, page_strobe}, 16'h0);
    rst_n = 1'b1;

    // Scan order/timing over two frames of page 0 (3A50)
    check_span(48, S0, S5, SA, S3, 4'b0000);

    // Debounce reject: 5-cycle glitch
    button = 1'b1;
    repeat (5) tick();
    button = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("glitch_strobe", {15'h0, page_strobe}, 16'h0);
    end
    chk("glitch_page", {14'h0, page}, 16'h0);

    // Page advance 0->1->2->0, then back to 1
    press(2'd0, 2'd1);
    press(2'd1, 2'd2);
    press(2'd2, 2'd0);
    press(2'd0, 2'd1);

    // Blank mask on page 1: only digit 0 (5) lit
    sync_phase(23);
    check_span(24, S5, S0, S0, S0, 4'b1110);

    // Mid-DRIVE page change: strobe lands in 2nd cycle of digit 1
    blank1 = 4'b0000;
    for (int i = 0; i < 25; i++) begin
      if (ncyc % 24 == 22) break;
      tick();
    end
    button = 1'b1;
    check_span(11, S5, S0, S0, S0, 4'b0000);
    chk("mid_page", {14'h0, page}, 16'h2);
    chk("mid_strobe", {15'h0, page_strobe}, 16'h1);
    check_span(16, SF, S0, SD, S4, 4'b0000);
    check_span(24, SF, S6, SD, S4, 4'b0000);
    button = 1'b0;
    repeat (15) tick();

    // Async reset mid-DRIVE
    sync_phase(2);
    chk("pre_rst_an", {12'h0, an}, 16'h000E);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {12'h0, an}, 16'h000F);
    chk("async_seg", {9'h0, seg}, 16'h007F);
    chk("async_page", {14'h0, page}, 16'h0);
    tick(); tick();
    rst_n = 1'b1;
    check_span(30, S0, S5, SA, S3, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
